// File: rtl/regfile_wb_sched_pkg.sv
// rtl/regfile_wb_sched_pkg.sv - shared register IDs, FSM encoding and helpers for the writeback scheduler
package regfile_wb_sched_pkg;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] RRAX = 4'h0;
    localparam logic [3:0] RRCX = 4'h1;
    localparam logic [3:0] RRDX = 4'h2;
    localparam logic [3:0] RRBX = 4'h3;
    localparam logic [3:0] RRSP = 4'h4;
    localparam logic [3:0] RRBP = 4'h5;
    localparam logic [3:0] RRSI = 4'h6;
    localparam logic [3:0] RRDI = 4'h7;
    localparam logic [3:0] RR8  = 4'h8;
    localparam logic [3:0] RR9  = 4'h9;
    localparam logic [3:0] RR10 = 4'hA;
    localparam logic [3:0] RR11 = 4'hB;
    localparam logic [3:0] RR12 = 4'hC;
    localparam logic [3:0] RR13 = 4'hD;
    localparam logic [3:0] RR14 = 4'hE;

    typedef enum logic {
        IDLE = 1'b0,
        WR_M = 1'b1
    } state_t;

    // True when the ID names a real architectural register
    function automatic logic is_reg(input logic [3:0] id);
        return id != RNONE;
    endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - writeback request and read-port bundle for the writeback scheduler
interface regfile_wb_sched_if #(
    parameter int DW = 64
);
    logic          wb_valid;
    logic          wb_ready;
    logic [3:0]    dstE;
    logic [DW-1:0] valE;
    logic [3:0]    dstM;
    logic [DW-1:0] valM;
    logic [3:0]    srcA;
    logic [3:0]    srcB;
    logic [DW-1:0] valA;
    logic [DW-1:0] valB;
    logic          busy;

    modport master (
        output wb_valid, dstE, valE, dstM, valM, srcA, srcB,
        input  wb_ready, valA, valB, busy
    );

    modport slave (
        input  wb_valid, dstE, valE, dstM, valM, srcA, srcB,
        output wb_ready, valA, valB, busy
    );
endinterface

// File: rtl/regfile_wb_sched_regfile_1w2r.sv
// rtl/regfile_wb_sched_regfile_1w2r.sv - register storage with one write port and two combinational read ports
module regfile_1w2r #(
    parameter int DW   = 64,
    parameter int NREG = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [3:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [3:0]    i_raddr_a,
    input  logic [3:0]    i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);
    import regfile_wb_sched_pkg::*;

    logic [DW-1:0] r_regs [NREG];

    // Storage: reset seeds register i with i+1; addresses past the file (RNONE) never write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= DW'(i + 1);
            end
        end else if (i_we && int'(i_waddr) < NREG) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (int'(i_raddr_a) < NREG) ? r_regs[i_raddr_a] : '0;
    assign o_rdata_b = (int'(i_raddr_b) < NREG) ? r_regs[i_raddr_b] : '0;

endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - serialises dual E/M writebacks onto a single-write-port register file
module regfile_wb_sched #(
    parameter int DW   = 64,
    parameter int NREG = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_sched_if.slave   bus
);
    import regfile_wb_sched_pkg::*;

    state_t        r_state;
    logic [3:0]    r_dstm;
    logic [DW-1:0] r_valm;
    logic          r_wb_ready;
    logic          r_busy;

    logic          w_accept;
    logic          w_e_ok;
    logic          w_m_ok;
    logic          w_split;
    logic          w_we;
    logic [3:0]    w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rf_a;
    logic [DW-1:0] w_rf_b;

    assign w_accept = bus.wb_valid && (r_state == IDLE);
    assign w_e_ok   = is_reg(bus.dstE);
    assign w_m_ok   = is_reg(bus.dstM);
    assign w_split  = w_e_ok && w_m_ok && (bus.dstE != bus.dstM);

    // Write-port mux: WR_M drains the latched M; in IDLE an accept writes E first on a split, else M wins
    always_comb begin
        w_we    = 1'b0;
        w_waddr = RNONE;
        w_wdata = '0;
        if (r_state == WR_M) begin
            w_we    = 1'b1;
            w_waddr = r_dstm;
            w_wdata = r_valm;
        end else if (w_accept) begin
            if (w_split) begin
                w_we    = 1'b1;
                w_waddr = bus.dstE;
                w_wdata = bus.valE;
            end else if (w_m_ok) begin
                w_we    = 1'b1;
                w_waddr = bus.dstM;
                w_wdata = bus.valM;
            end else if (w_e_ok) begin
                w_we    = 1'b1;
                w_waddr = bus.dstE;
                w_wdata = bus.valE;
            end
        end
    end

    // Scheduler FSM with registered ready/busy and the pending-M latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dstm     <= RNONE;
            r_valm     <= '0;
            r_wb_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_split) begin
                        r_state    <= WR_M;
                        r_dstm     <= bus.dstM;
                        r_valm     <= bus.valM;
                        r_wb_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                WR_M: begin
                    r_state    <= IDLE;
                    r_dstm     <= RNONE;
                    r_valm     <= '0;
                    r_wb_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_wb_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    regfile_1w2r #(
        .DW   (DW),
        .NREG (NREG)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (bus.srcA),
        .i_raddr_b (bus.srcB),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

    // Pending M is architecturally committed already, so reads of its register see it early
    assign bus.valA     = (r_state == WR_M && bus.srcA == r_dstm) ? r_valm : w_rf_a;
    assign bus.valB     = (r_state == WR_M && bus.srcB == r_dstm) ? r_valm : w_rf_b;
    assign bus.wb_ready = r_wb_ready;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - randomized self-checking bench for the writeback scheduler
`timescale 1ns/1ps
module tb_regfile_wb_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_sched_if #(.DW(64)) bus();

    regfile_wb_sched #(.DW(64), .NREG(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] mdl [15];
    logic        m_pend;
    logic [3:0]  m_pdst;
    logic [63:0] m_pval;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 15; i++) mdl[i] = 64'(i + 1);
        m_pend = 1'b0;
        m_pdst = 4'hF;
        m_pval = '0;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] a);
        if (m_pend && a == m_pdst) return m_pval;
        if (a == 4'hF) return 64'd0;
        return mdl[a];
    endfunction

    function automatic logic [3:0] rnd_id();
        if ($urandom_range(0, 3) == 0) return 4'hF;
        return 4'($urandom_range(0, 14));
    endfunction

    task automatic drive(input logic v, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        bus.wb_valid = v;
        bus.dstE = de;
        bus.valE = ve;
        bus.dstM = dm;
        bus.valM = vm;
    endtask

    task automatic idle();
        drive(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    endtask

    // Apply the request-level rules to the model, then advance one clock to the next negedge
    task automatic tick();
        logic e_ok, m_ok;
        e_ok = bus.dstE != 4'hF;
        m_ok = bus.dstM != 4'hF;
        if (m_pend) begin
            mdl[m_pdst] = m_pval;
            m_pend = 1'b0;
        end else if (bus.wb_valid) begin
            if (e_ok && m_ok && bus.dstE != bus.dstM) begin
                mdl[bus.dstE] = bus.valE;
                m_pend = 1'b1;
                m_pdst = bus.dstM;
                m_pval = bus.valM;
            end else begin
                if (e_ok && !m_ok) mdl[bus.dstE] = bus.valE;
                if (m_ok) mdl[bus.dstM] = bus.valM;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ready"}, 64'(bus.wb_ready), 64'(!m_pend));
        chk({tag, ".busy"},  64'(bus.busy),     64'(m_pend));
        chk({tag, ".valA"},  bus.valA, m_read(bus.srcA));
        chk({tag, ".valB"},  bus.valB, m_read(bus.srcB));
    endtask

    // Sweep every register through both read ports; only valid with no request and nothing pending
    task automatic read_all(input string tag);
        for (int r = 0; r < 15; r++) begin
            bus.srcA = 4'(r);
            bus.srcB = 4'(14 - r);
            #1;
            chk({tag, ".A"}, bus.valA, m_read(bus.srcA));
            chk({tag, ".B"}, bus.valB, m_read(bus.srcB));
        end
        bus.srcA = 4'hF;
        #1;
        chk({tag, ".rnone"}, bus.valA, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        logic [3:0] de, dm;
        m_reset();
        idle();
        bus.srcA = 4'd0;
        bus.srcB = 4'd14;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        #1;
        chk("rst.valA",  bus.valA, 64'd1);
        chk("rst.valB",  bus.valB, 64'd15);
        chk("rst.ready", 64'(bus.wb_ready), 64'd1);
        chk("rst.busy",  64'(bus.busy), 64'd0);

        drive(1'b1, 4'd2, 64'hAA, 4'hF, 64'd0);
        tick();
        idle();
        bus.srcA = 4'd2;
        #1;
        chk("e_only.valA",  bus.valA, 64'hAA);
        chk("e_only.ready", 64'(bus.wb_ready), 64'd1);

        drive(1'b1, 4'd4, 64'h100, 4'd3, 64'h55);
        tick();
        idle();
        bus.srcA = 4'd4;
        bus.srcB = 4'd3;
        #1;
        chk("split1.reg4",  bus.valA, 64'h100);
        chk("split1.byp3",  bus.valB, 64'h55);
        chk("split1.busy",  64'(bus.busy), 64'd1);
        chk("split1.ready", 64'(bus.wb_ready), 64'd0);
        tick();
        #1;
        chk("split2.reg3",  bus.valB, 64'h55);
        chk("split2.busy",  64'(bus.busy), 64'd0);

        drive(1'b1, 4'd4, 64'h10, 4'd4, 64'h20);
        tick();
        idle();
        bus.srcA = 4'd4;
        #1;
        chk("same.reg4", bus.valA, 64'h20);
        chk("same.busy", 64'(bus.busy), 64'd0);
        read_all("dir");

        acc = 0;
        for (int c = 0; c < 20; c++) begin
            de = 4'($urandom_range(0, 14));
            dm = 4'((int'(de) + 1 + $urandom_range(0, 13)) % 15);
            drive(1'b1, de, {$urandom, $urandom}, dm, {$urandom, $urandom});
            bus.srcA = 4'($urandom_range(0, 15));
            bus.srcB = dm;
            #1;
            check_outputs("b2b");
            if (bus.wb_ready) acc++;
            tick();
        end
        chk("b2b.accepts", 64'(acc), 64'd10);
        idle();
        if (m_pend) tick();
        read_all("b2b.end");

        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), rnd_id(), {$urandom, $urandom},
                  rnd_id(), {$urandom, $urandom});
            bus.srcA = 4'($urandom_range(0, 15));
            bus.srcB = ($urandom_range(0, 1) == 1 && m_pend) ? m_pdst : 4'($urandom_range(0, 15));
            #1;
            check_outputs("rnd");
            tick();
        end
        idle();
        if (m_pend) tick();
        read_all("rnd.end");

        drive(1'b1, 4'd6, 64'hDEAD, 4'd7, 64'hBEEF);
        tick();
        idle();
        #1;
        chk("rstbusy.busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rstbusy.ready", 64'(bus.wb_ready), 64'd1);
        chk("rstbusy.busy0", 64'(bus.busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read_all("rstbusy");

        drive(1'b1, 4'd5, 64'h77, 4'hF, 64'd0);
        tick();
        idle();
        bus.srcA = 4'd5;
        #1;
        chk("post_rst.reg5", bus.valA, 64'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter DW, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 15, architectural register count (IDs 0..14); ID 4'hF is RNONE (no register).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb_valid  input  1  writeback request present.
REQ-006 SHALL have port wb_ready  output  1  scheduler can accept a writeback request this cycle.
REQ-007 SHALL have port dstE  input  4  destination for valE; RNONE = no write.
REQ-008 SHALL have port valE  input  DW  execute-result write data.
REQ-009 SHALL have port dstM  input  4  destination for valM; RNONE = no write.
REQ-010 SHALL have port valM  input  DW  memory-result write data.
REQ-011 SHALL have port srcA  input  4  read port A address.
REQ-012 SHALL have port srcB  input  4  read port B address.
REQ-013 SHALL have port valA  output  DW  read port A data.
REQ-014 SHALL have port valB  output  DW  read port B data.
REQ-015 SHALL have port busy  output  1  second write of a split writeback is pending.

Function
REQ-016 SHALL hold NREG x DW register storage with exactly one physical write port; the scheduler serialises all writes onto it.
REQ-017 SHALL accept a request only on a cycle where wb_valid && wb_ready are both 1; inputs are ignored on other cycles.
REQ-018 SHALL use FSM states IDLE and WR_M; wb_ready = 1 in IDLE, 0 in WR_M; busy = (state == WR_M).
REQ-019 On accept with exactly one of dstE/dstM not RNONE: SHALL write that value at that edge, remain IDLE.
REQ-020 On accept with both RNONE: SHALL write nothing, remain IDLE.
REQ-021 On accept with both valid and dstE != dstM: SHALL write valE to dstE at that edge, latch dstM/valM, go to WR_M.
REQ-022 In WR_M: SHALL write latched valM to latched dstM at the next edge, then return to IDLE (split writeback occupies exactly 2 cycles; back-to-back throughput 1 request per 2 cycles).
REQ-023 On accept with both valid and dstE == dstM: SHALL write valM only (M has priority), single cycle, remain IDLE.
REQ-024 valA/valB SHALL be combinational reads of current storage; srcA/srcB = RNONE SHALL read 0.
REQ-025 In WR_M, a read whose address equals latched dstM SHALL return latched valM (bypass); all other reads return storage.
REQ-026 No bypass SHALL exist for the same-cycle write in IDLE; the written value is visible on reads the cycle after the edge.
REQ-027 Writes to RNONE SHALL never modify storage.

Reset
REQ-028 On rst_n = 0 SHALL immediately (asynchronously) force state IDLE, wb_ready = 1, busy = 0, clear latched dstM to RNONE, latched valM to 0.
REQ-029 On reset SHALL initialise register i to i+1 (reg 0 = 1 ... reg 14 = 15).
REQ-030 Reset asserted during WR_M SHALL discard the pending M write.
REQ-031 First accept SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package SHALL hold RNONE (4'hF), FSM state encoding, and register-ID constants (RRSP = 4'h4 etc.).
REQ-033 Register storage SHALL be a sub-module regfile_1w2r (one write port, two combinational read ports); regfile_wb_sched holds the FSM, latch and bypass.

Verification
REQ-034 Reset -> srcA=0, srcB=14 gives valA=1, valB=15; wb_ready=1, busy=0.
REQ-035 Accept dstE=2, valE=0xAA, dstM=RNONE -> next cycle srcA=2 reads 0xAA; wb_ready stays 1.
REQ-036 Accept dstE=4, valE=0x100, dstM=3, valM=0x55 -> cycle+1: reg4=0x100, busy=1, wb_ready=0, srcB=3 reads 0x55 via bypass; cycle+2: reg3=0x55, busy=0.
REQ-037 Accept dstE=4, valE=0x10, dstM=4, valM=0x20 -> reg4=0x20, busy never asserts.
REQ-038 wb_valid held high with split requests every cycle -> exactly one accept per 2 cycles, no write lost or duplicated.
REQ-039 rst_n pulsed low while busy=1 -> pending M write dropped, all registers at reset values, wb_ready=1 at once.
